// File: rtl/lz4_obuf_packer_if.sv
// Byte-stream input and host-side FIFO read bundle of the LZ4 output packer.
// The packer is the slave; the sequence encoder and host read port are the master.
interface lz4_obuf_packer_if;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        in_valid;
  logic        in_ready;
  logic        out_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_empty;
  logic        obuf_full;
  logic        ohalf_full;

  modport slave (
    input  in_data, in_bytes, in_valid, out_en,
    output in_ready, out_data, out_valid, out_empty, obuf_full, ohalf_full
  );

  modport master (
    output in_data, in_bytes, in_valid, out_en,
    input  in_ready, out_data, out_valid, out_empty, obuf_full, ohalf_full
  );
endinterface

// File: rtl/lz4_obuf_packer.sv
// Packs 0-4 compressed bytes per cycle into 32-bit words, buffers them in an
// on-chip FIFO for the host, counts bytes and pads the final word on flush.
module lz4_obuf_packer #(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  output logic        flush_done,
  output logic [31:0] compressed_len,
  lz4_obuf_packer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, PAD, DONE} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

  state_t      state_q;
  logic [7:0]  stage_q [8];
  logic [7:0]  stage_d [8];
  logic [3:0]  scnt_q, scnt_d, base_cnt;
  logic [31:0] len_q;
  logic        fd_q;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [31:0]   rdata_q;
  logic          rvalid_q;

  logic        full, empty, emit, pad_wr, wr_en, rd_acc, in_ready, accept;
  logic [2:0]  nb;
  logic [31:0] wr_word;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign emit     = (scnt_q >= 4'd4) && !full;
  assign pad_wr   = (state_q == PAD) && !full;
  assign wr_en    = (emit || pad_wr) && !rst;
  assign rd_acc   = bus.out_en && !empty;
  assign in_ready = (state_q == RUN) && ((scnt_q <= 4'd3) || emit);
  assign accept   = bus.in_valid && in_ready;
  assign nb       = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;

  // Oldest bytes go MSB-first; lanes past scnt are zero, which is the pad fill.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wr_word[31-8*gi -: 8] = (scnt_q > 4'(gi)) ? stage_q[gi] : 8'h00;
  end

  always_comb begin
    base_cnt = emit ? (scnt_q - 4'd4) : scnt_q;
    for (int i = 0; i < 4; i++) stage_d[i] = emit ? stage_q[i+4] : stage_q[i];
    for (int i = 4; i < 8; i++) stage_d[i] = stage_q[i];
    for (int k = 0; k < 4; k++) begin
      if (accept && (3'(k) < nb)) stage_d[3'(base_cnt + 4'(k))] = bus.in_data[31-8*k -: 8];
    end
    scnt_d = base_cnt + (accept ? {1'b0, nb} : 4'd0);
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      len_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (start) begin
        state_q <= RUN;
        scnt_q  <= '0;
        len_q   <= '0;
      end else begin
        scnt_q <= scnt_d;
        if (accept) len_q <= len_q + 32'(nb);
        case (state_q)
          IDLE: if (flush) begin
            state_q <= DONE;
            fd_q    <= 1'b1;
          end
          RUN: if (flush) state_q <= DRAIN;
          DRAIN: if (scnt_q < 4'd4) begin
            if (scnt_q == 4'd0) begin
              state_q <= DONE;
              fd_q    <= 1'b1;
            end else begin
              state_q <= PAD;
            end
          end
          PAD: if (!full) begin
            state_q <= DONE;
            scnt_q  <= '0;
            fd_q    <= 1'b1;
          end
          DONE: if (flush) fd_q <= 1'b1;
                else       state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rdata_q  <= mem[rd_ptr_q];
      end
      case ({wr_en, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_data   = rdata_q;
  assign bus.out_valid  = rvalid_q;
  assign bus.out_empty  = empty;
  assign bus.obuf_full  = full;
  assign bus.ohalf_full = (count_q >= HALF_CNT);
  assign flush_done     = fd_q;
  assign compressed_len = len_q;
endmodule

// File: tb/tb_lz4_obuf_packer.sv
// Directed bench for lz4_obuf_packer: a byte-queue model predicts every word the
// host reads and the running byte count; literal checks pin the model.
module tb_lz4_obuf_packer;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic        flush_done;
  logic [31:0] compressed_len;

  lz4_obuf_packer_if bus ();

  lz4_obuf_packer #(.DEPTH(8192), .AW(13)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .flush_done(flush_done), .compressed_len(compressed_len), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;

  logic [7:0]  byte_q [$];
  logic [31:0] exp_q  [$];
  logic [31:0] m_len = 0;
  logic        m_run = 0;
  int          m_n;
  logic [31:0] m_w, c_w;
  logic [31:0] got [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: ordered byte stream; every 4 bytes form a word; flush pads the tail.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      byte_q.delete(); exp_q.delete(); m_len = 0; m_run = 0;
    end else if (start) begin
      byte_q.delete(); m_len = 0; m_run = 1;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        m_n = (bus.in_bytes > 3'd4) ? 4 : int'(bus.in_bytes);
        for (int k = 0; k < m_n; k++) byte_q.push_back(bus.in_data[31-8*k -: 8]);
        m_len = m_len + 32'(m_n);
      end
      while (byte_q.size() >= 4) begin
        m_w = {byte_q[0], byte_q[1], byte_q[2], byte_q[3]};
        for (int k = 0; k < 4; k++) void'(byte_q.pop_front());
        exp_q.push_back(m_w);
      end
      if (flush && m_run) begin
        if (byte_q.size() > 0) begin
          m_w = '0;
          for (int k = 0; k < byte_q.size(); k++) m_w[31-8*k -: 8] = byte_q[k];
          exp_q.push_back(m_w);
        end
        byte_q.delete();
        m_run = 0;
      end
    end
  end

  // Compare process: every read word and the byte count, every cycle.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (flush_done) fd_cnt++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_word", bus.out_data, 32'hxxxxxxxx);
        else begin
          c_w = exp_q.pop_front();
          chk("word", bus.out_data, c_w);
        end
      end
      chk("compressed_len", compressed_len, m_len);
    end
  end

  // Tasks are entered at a falling edge and return at a falling edge.
  task automatic send(input logic [31:0] d, input logic [2:0] n, input logic f);
    int t = 0;
    bus.in_data = d; bus.in_bytes = n; bus.in_valid = 1'b1; flush = f;
    while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
    if (!bus.in_ready) chk("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_fd(input int fd0);
    int t = 0;
    while (fd_cnt == fd0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("flush_done_once", 32'(fd_cnt - fd0), 32'd1);
  endtask

  task automatic do_flush();
    int fd0 = fd_cnt;
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    wait_fd(fd0);
  endtask

  // Hold out_en through the read that finds the FIFO empty.
  task automatic host_drain(input int k);
    bus.out_en = 1'b1;
    for (int i = 0; i <= k; i++) begin
      @(negedge clk);
      chk("host_valid", {31'd0, bus.out_valid}, {31'd0, (i < k)});
      if (i < k) chk("host_empty", {31'd0, bus.out_empty}, {31'd0, (i == k-1)});
      if (i < k && i < 16) got[i] = bus.out_data;
    end
    bus.out_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    bus.in_data = '0; bus.in_bytes = '0; bus.in_valid = 1'b0; bus.out_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",   {31'd0, bus.in_ready},   32'd0);
    chk("rst_flush_done", {31'd0, flush_done},     32'd0);
    chk("rst_out_data",   bus.out_data,            32'd0);
    chk("rst_out_valid",  {31'd0, bus.out_valid},  32'd0);
    chk("rst_out_empty",  {31'd0, bus.out_empty},  32'd1);
    chk("rst_obuf_full",  {31'd0, bus.obuf_full},  32'd0);
    chk("rst_ohalf_full", {31'd0, bus.ohalf_full}, 32'd0);
    chk("rst_len",        compressed_len,          32'd0);
    rst = 1'b0;

    // Four full words, no pad.
    do_start();
    send(32'h01020304, 3'd4, 1'b0);
    send(32'h05060708, 3'd4, 1'b0);
    send(32'h090A0B0C, 3'd4, 1'b0);
    send(32'h0D0E0F10, 3'd4, 1'b0);
    do_flush();
    chk("t1_len", compressed_len, 32'd16);
    host_drain(4);
    chk("t1_w0", got[0], 32'h01020304);
    chk("t1_w1", got[1], 32'h05060708);
    chk("t1_w2", got[2], 32'h090A0B0C);
    chk("t1_w3", got[3], 32'h0D0E0F10);

    // Flush while idle: one pulse, nothing written.
    do_flush();
    chk("idle_flush_empty", {31'd0, bus.out_empty}, 32'd1);

    // 3+2+1 bytes with junk in unused lanes, padded tail.
    do_start();
    send(32'hAABBCC99, 3'd3, 1'b0);
    send(32'hDDEE5566, 3'd2, 1'b0);
    send(32'hFF123456, 3'd1, 1'b0);
    do_flush();
    chk("t2_len", compressed_len, 32'd6);
    host_drain(2);
    chk("t2_w0", got[0], 32'hAABBCCDD);
    chk("t2_w1", got[1], 32'hEEFF0000);

    // Oversized count saturates to 4; zero-byte beat is a no-op.
    do_start();
    send(32'h11223344, 3'd7, 1'b0);
    send(32'hDEADBEEF, 3'd0, 1'b0);
    do_flush();
    chk("t3_len", compressed_len, 32'd4);
    host_drain(1);
    chk("t3_w0", got[0], 32'h11223344);

    // Flush together with a 2-byte beat while one byte is staged.
    do_start();
    send(32'h00ABCDEF, 3'd1, 1'b0);
    chk("t4_len1", compressed_len, 32'd1);
    fd0 = fd_cnt;
    send(32'h11223344, 3'd2, 1'b1);
    wait_fd(fd0);
    chk("t4_len3", compressed_len, 32'd3);
    host_drain(1);
    chk("t4_w0", got[0], 32'h00112200);

    // Reset in DRAIN with a word in the FIFO and 6 bytes staged.
    do_start();
    send(32'h99887766, 3'd4, 1'b0);
    send(32'hA1A2A3FF, 3'd3, 1'b0);
    send(32'hB1B2B3FF, 3'd3, 1'b1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("t5_empty",    {31'd0, bus.out_empty}, 32'd1);
    chk("t5_len",      compressed_len,         32'd0);
    chk("t5_fd",       {31'd0, flush_done},    32'd0);
    chk("t5_in_ready", {31'd0, bus.in_ready},  32'd0);
    fd0 = fd_cnt;
    repeat (10) @(negedge clk);
    chk("t5_no_fd", 32'(fd_cnt - fd0), 32'd0);
    do_start();
    send(32'hCAFEBABE, 3'd4, 1'b0);
    do_flush();
    chk("t5_len_after", compressed_len, 32'd4);
    host_drain(1);
    chk("t5_w0", got[0], 32'hCAFEBABE);

    // Fill to full with no reads, then read half while the producer resumes.
    do_start();
    for (int i = 1; i <= 8193; i++) begin
      send(32'h40000000 + 32'(i), 3'd4, 1'b0);
      if (i == 4096) chk("fill_half_before", {31'd0, bus.ohalf_full}, 32'd0);
      if (i == 4097) chk("fill_half_after",  {31'd0, bus.ohalf_full}, 32'd1);
      if (i == 8192) begin
        chk("fill_full_before", {31'd0, bus.obuf_full}, 32'd0);
        chk("fill_ready_before", {31'd0, bus.in_ready}, 32'd1);
      end
      if (i == 8193) begin
        chk("fill_full_after", {31'd0, bus.obuf_full}, 32'd1);
        chk("fill_ready_drop", {31'd0, bus.in_ready}, 32'd0);
      end
    end
    fork
      begin
        for (int i = 8194; i <= 8200; i++) send(32'h40000000 + 32'(i), 3'd4, 1'b0);
      end
      begin
        bus.out_en = 1'b1;
        @(negedge clk);
        chk("fill_full_clear", {31'd0, bus.obuf_full}, 32'd0);
        repeat (4095) @(negedge clk);
        bus.out_en = 1'b0;
      end
    join
    do_flush();
    chk("fill_len", compressed_len, 32'd32800);
    host_drain(4104);
    chk("fill_model_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
